// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_accumulator
// Brief    : Registered adder-tree lane reduction with per-vector accumulation
//            and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_accumulator #(
  parameter int N             = 8,
  parameter int NUM_INSTANCES = 20,
  parameter int ACC_W         = 32,
  parameter int BEAT_W        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2*N*NUM_INSTANCES-1:0]    in_products,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [ACC_W-1:0]                out_data,
  output logic [BEAT_W-1:0]               out_beats,
  output logic                            out_overflow,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int LANE_W = 2 * N;
  localparam int L      = (NUM_INSTANCES <= 2) ? 1 : $clog2(NUM_INSTANCES);
  localparam int P      = 1 << L;
  localparam int SUM_W  = LANE_W + L;

  logic              w_stall;
  logic [L-1:0]      vld_q;
  logic [L-1:0]      last_q;
  logic [LANE_W-1:0] w_lane [P];
  logic [SUM_W-1:0]  w_tree;
  logic [ACC_W-1:0]  w_sum;
  logic              w_trunc;

  logic [ACC_W-1:0]  acc_q;
  logic [BEAT_W-1:0] beats_q;
  logic              ovf_q;
  logic [ACC_W-1:0]  out_data_q;
  logic [BEAT_W-1:0] out_beats_q;
  logic              out_ovf_q;
  logic              out_valid_q;

  logic [ACC_W:0]    acc_d;
  logic [BEAT_W-1:0] beats_d;
  logic              ovf_d;

  assign w_stall  = out_valid_q && !out_ready;
  assign in_ready = !w_stall;

  for (genvar i = 0; i < P; i++) begin : g_lane
    if (i < NUM_INSTANCES) begin : g_real
      assign w_lane[i] = in_products[LANE_W*i +: LANE_W];
    end else begin : g_pad
      assign w_lane[i] = '0;
    end
  end

  // Level k holds P>>k partial sums, each one bit wider than the level below.
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int WK    = LANE_W + k;
    localparam int NODES = P >> k;
    for (genvar j = 0; j < NODES; j++) begin : g_node
      logic [WK-1:0] sum_q;
      logic [WK-2:0] w_a;
      logic [WK-2:0] w_b;
      if (k == 1) begin : g_leaf
        assign w_a = w_lane[2*j];
        assign w_b = w_lane[2*j+1];
      end else begin : g_inner
        assign w_a = g_lvl[k-1].g_node[2*j].sum_q;
        assign w_b = g_lvl[k-1].g_node[2*j+1].sum_q;
      end
      always_ff @(posedge clk) begin
        if (!w_stall) begin
          sum_q <= {1'b0, w_a} + {1'b0, w_b};
        end
      end
    end
  end

  assign w_tree = g_lvl[L].g_node[0].sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (!w_stall) begin
      vld_q[0] <= in_valid;
      for (int s = 1; s < L; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      last_q[0] <= in_last;
      for (int s = 1; s < L; s++) begin
        last_q[s] <= last_q[s-1];
      end
    end
  end

  // Bits dropped by truncation count as overflow of the vector sum.
  if (ACC_W >= SUM_W) begin : g_ext
    assign w_sum   = ACC_W'(w_tree);
    assign w_trunc = 1'b0;
  end else begin : g_trunc
    assign w_sum   = w_tree[ACC_W-1:0];
    assign w_trunc = |w_tree[SUM_W-1:ACC_W];
  end

  assign acc_d   = {1'b0, acc_q} + {1'b0, w_sum};
  assign ovf_d   = ovf_q | acc_d[ACC_W] | w_trunc;
  assign beats_d = (&beats_q) ? beats_q : beats_q + BEAT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!w_stall) begin
      out_valid_q <= vld_q[L-1] && last_q[L-1];
      if (vld_q[L-1]) begin
        if (last_q[L-1]) begin
          out_data_q  <= acc_d[ACC_W-1:0];
          out_beats_q <= beats_d;
          out_ovf_q   <= ovf_d;
          acc_q       <= '0;
          beats_q     <= '0;
          ovf_q       <= 1'b0;
        end else begin
          acc_q       <= acc_d[ACC_W-1:0];
          beats_q     <= beats_d;
          ovf_q       <= ovf_d;
        end
      end
    end
  end

  assign out_data     = out_data_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;
  assign out_valid    = out_valid_q;

endmodule
`default_nettype wire
